// File: rtl/fpga_cfg_loader.sv
// fpga_cfg_loader: configuration sequencer for the fpga_core chain.
// Takes a byte stream over valid/ready and shifts it MSB-first into the
// chain on ccff_head/prog_clk. It then releases isol_n and, after a hold
// time, core_reset.
// Optional CRC-16-CCITT trailer check: define FPGA_CFG_LOADER_CRC_EN.
module fpga_cfg_loader #(
  parameter int CNT_W      = 20,
  parameter int DIV_W      = 8,
  parameter int RST_CYCLES = 16
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             start,
  input  logic [CNT_W-1:0] bit_count,
  input  logic [DIV_W-1:0] clk_div,
  input  logic [7:0]       s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic             prog_clk,
  output logic             prog_reset,
  output logic             ccff_head,
  output logic             isol_n,
  output logic             core_reset,
  output logic             busy,
  output logic             done,
  output logic             error
);

  localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int BW = CNT_W - 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRST,
    S_SHIFT,
    S_REL
`ifdef FPGA_CFG_LOADER_CRC_EN
    , S_CRC
`endif
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] bits, bits_n;
  logic [BW-1:0]    bytes_left, bytes_n;
  logic [CNT_W:0]   bytes_sum;
  logic [DIV_W-1:0] div_q, div_n;
  logic [DIV_W-1:0] pcnt, pcnt_n;
  logic [RW-1:0]    rcnt, rcnt_n;
  logic [7:0]       buf_data, buf_data_n;
  logic             buf_full, buf_full_n;
  logic [7:0]       shreg, shreg_n;
  logic [3:0]       sh_cnt, sh_cnt_n;
  logic             have_bit, have_bit_n;
  logic             fetch_req, got_bit, bit_v;
  logic             s_ready_n, prog_clk_n, prog_reset_n, ccff_n;
  logic             isol_n_n, core_reset_n, busy_n, done_n, error_n;
`ifdef FPGA_CFG_LOADER_CRC_EN
  logic [15:0]      crc, crc_n;
  logic [7:0]       crc_hi, crc_hi_n;
  logic [1:0]       crc_cnt, crc_cnt_n;
`endif

  // State and output registers; every output is driven straight from a flop.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state      <= S_IDLE;
      bits       <= '0;
      bytes_left <= '0;
      div_q      <= DIV_W'(1);
      pcnt       <= '0;
      rcnt       <= '0;
      buf_data   <= '0;
      buf_full   <= 1'b0;
      shreg      <= '0;
      sh_cnt     <= '0;
      have_bit   <= 1'b0;
      s_ready    <= 1'b0;
      prog_clk   <= 1'b0;
      prog_reset <= 1'b1;
      ccff_head  <= 1'b0;
      isol_n     <= 1'b0;
      core_reset <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
`ifdef FPGA_CFG_LOADER_CRC_EN
      crc        <= 16'hFFFF;
      crc_hi     <= '0;
      crc_cnt    <= '0;
`endif
    end else begin
      state      <= state_n;
      bits       <= bits_n;
      bytes_left <= bytes_n;
      div_q      <= div_n;
      pcnt       <= pcnt_n;
      rcnt       <= rcnt_n;
      buf_data   <= buf_data_n;
      buf_full   <= buf_full_n;
      shreg      <= shreg_n;
      sh_cnt     <= sh_cnt_n;
      have_bit   <= have_bit_n;
      s_ready    <= s_ready_n;
      prog_clk   <= prog_clk_n;
      prog_reset <= prog_reset_n;
      ccff_head  <= ccff_n;
      isol_n     <= isol_n_n;
      core_reset <= core_reset_n;
      busy       <= busy_n;
      done       <= done_n;
      error      <= error_n;
`ifdef FPGA_CFG_LOADER_CRC_EN
      crc        <= crc_n;
      crc_hi     <= crc_hi_n;
      crc_cnt    <= crc_cnt_n;
`endif
    end
  end

  // Next-state and next-output logic for the load sequence.
  always_comb begin
    state_n      = state;
    bits_n       = bits;
    bytes_n      = bytes_left;
    div_n        = div_q;
    pcnt_n       = pcnt;
    rcnt_n       = rcnt;
    buf_data_n   = buf_data;
    buf_full_n   = buf_full;
    shreg_n      = shreg;
    sh_cnt_n     = sh_cnt;
    have_bit_n   = have_bit;
    prog_clk_n   = prog_clk;
    prog_reset_n = prog_reset;
    ccff_n       = ccff_head;
    isol_n_n     = isol_n;
    core_reset_n = core_reset;
    busy_n       = busy;
    done_n       = done;
    error_n      = error;
    fetch_req    = 1'b0;
    got_bit      = 1'b0;
    bit_v        = 1'b0;
    bytes_sum    = {1'b0, bit_count} + (CNT_W+1)'(7);
`ifdef FPGA_CFG_LOADER_CRC_EN
    crc_n        = crc;
    crc_hi_n     = crc_hi;
    crc_cnt_n    = crc_cnt;
`endif

    case (state)
      S_IDLE: begin
        if (start) begin
          bits_n  = bit_count;
          div_n   = (clk_div == '0) ? DIV_W'(1) : clk_div;
          // Number of bytes to accept is ceil(bit_count/8).
          bytes_n = bytes_sum[CNT_W:3];
          done_n  = 1'b0;
          error_n = 1'b0;
          if (bit_count == '0) begin
            error_n = 1'b1;
            busy_n  = 1'b0;
          end else begin
            busy_n       = 1'b1;
            state_n      = S_PRST;
            prog_reset_n = 1'b1;
            prog_clk_n   = 1'b0;
            isol_n_n     = 1'b0;
            core_reset_n = 1'b1;
            rcnt_n       = '0;
            pcnt_n       = '0;
            buf_full_n   = 1'b0;
            sh_cnt_n     = '0;
            have_bit_n   = 1'b0;
`ifdef FPGA_CFG_LOADER_CRC_EN
            crc_n        = 16'hFFFF;
            crc_cnt_n    = '0;
`endif
          end
        end
      end

      S_PRST: begin
        if (rcnt == RW'(RST_CYCLES - 1)) begin
          prog_reset_n = 1'b0;
          state_n      = S_SHIFT;
        end else begin
          rcnt_n = rcnt + RW'(1);
        end
      end

      S_SHIFT: begin
        // s_ready high means the buffer is empty, so a transfer never
        // coincides with the buffer being drained below.
        if (s_valid && s_ready) begin
          buf_data_n = s_data;
          buf_full_n = 1'b1;
          bytes_n    = bytes_left - BW'(1);
        end
        // The next bit is fetched on the falling edge itself so that an
        // unstalled stream keeps a 2D period; a failed fetch parks low.
        if (!have_bit) begin
          fetch_req = 1'b1;
        end else if (pcnt != '0) begin
          pcnt_n = pcnt - DIV_W'(1);
        end else if (!prog_clk) begin
          prog_clk_n = 1'b1;
          pcnt_n     = div_q - DIV_W'(1);
          bits_n     = bits - CNT_W'(1);
        end else begin
          prog_clk_n = 1'b0;
          pcnt_n     = div_q - DIV_W'(1);
          if (bits == '0) begin
            have_bit_n = 1'b0;
            sh_cnt_n   = '0;
            buf_full_n = 1'b0;
`ifdef FPGA_CFG_LOADER_CRC_EN
            state_n    = S_CRC;
`else
            state_n    = S_REL;
            isol_n_n   = 1'b1;
            rcnt_n     = '0;
`endif
          end else begin
            fetch_req = 1'b1;
          end
        end
        if (fetch_req) begin
          if (sh_cnt != '0) begin
            bit_v    = shreg[7];
            shreg_n  = {shreg[6:0], 1'b0};
            sh_cnt_n = sh_cnt - 4'd1;
            got_bit  = 1'b1;
          end else if (buf_full) begin
            bit_v      = buf_data[7];
            shreg_n    = {buf_data[6:0], 1'b0};
            sh_cnt_n   = 4'd7;
            buf_full_n = 1'b0;
            got_bit    = 1'b1;
          end
          if (got_bit) begin
            ccff_n     = bit_v;
            have_bit_n = 1'b1;
            pcnt_n     = div_q - DIV_W'(1);
`ifdef FPGA_CFG_LOADER_CRC_EN
            crc_n      = {crc[14:0], 1'b0} ^ ((crc[15] ^ bit_v) ? 16'h1021 : 16'h0000);
`endif
          end else begin
            have_bit_n = 1'b0;
          end
        end
      end

`ifdef FPGA_CFG_LOADER_CRC_EN
      S_CRC: begin
        if (s_valid && s_ready) begin
          if (crc_cnt == 2'd0) begin
            crc_hi_n  = s_data;
            crc_cnt_n = 2'd1;
          end else begin
            crc_cnt_n = 2'd2;
            if ({crc_hi, s_data} == crc) begin
              state_n  = S_REL;
              isol_n_n = 1'b1;
              rcnt_n   = '0;
            end else begin
              state_n = S_IDLE;
              error_n = 1'b1;
              busy_n  = 1'b0;
            end
          end
        end
      end
`endif

      S_REL: begin
        if (rcnt == RW'(RST_CYCLES - 1)) begin
          core_reset_n = 1'b0;
          done_n       = 1'b1;
          busy_n       = 1'b0;
          state_n      = S_IDLE;
        end else begin
          rcnt_n = rcnt + RW'(1);
        end
      end

      default: state_n = S_IDLE;
    endcase

    s_ready_n = (state_n == S_SHIFT) && !buf_full_n && (bytes_n != '0);
`ifdef FPGA_CFG_LOADER_CRC_EN
    if (state_n == S_CRC && crc_cnt_n != 2'd2) s_ready_n = 1'b1;
`endif
  end

endmodule

// File: doc/fpga_cfg_loader.md
Name: fpga_cfg_loader

Overview:
- On-chip configuration sequencer for the fpga_core configuration chain.
- Accepts a bitstream as a byte stream over a valid/ready interface.
- Generates prog_clk, prog_reset and ccff_head to shift the bitstream into the chain, then releases isol_n and core reset.
- Sits in the user wrapper between a byte source (GPIO/SPI front end) and fpga_core; replaces direct pad drive of the programming pins.

Parameters:
- CNT_W, 20: width of bit_count and the internal bit counter.
- DIV_W, 8: width of clk_div.
- RST_CYCLES, 16: clk cycles prog_reset is held at the start of a load; also the cycles core_reset is held after isol_n rises.

Ports:
- clk  input  1  system clock
- resetb  input  1  asynchronous active-low reset
- start  input  1  single-cycle load request; sampled only in IDLE
- bit_count  input  CNT_W  number of config bits to shift; latched on start
- clk_div  input  DIV_W  prog_clk half-period in clk cycles; latched on start; 0 treated as 1
- s_data  input  8  bitstream byte, MSB shifted first
- s_valid  input  1  s_data valid
- s_ready  output  1  loader accepts byte
- prog_clk  output  1  configuration chain clock
- prog_reset  output  1  configuration chain reset, active high
- ccff_head  output  1  serial config data to chain
- isol_n  output  1  fabric I/O isolation release, active high
- core_reset  output  1  fabric user reset, active high
- busy  output  1  load in progress
- done  output  1  load completed successfully; held until next accepted start
- error  output  1  load failed; held until next accepted start

Behaviour:
- Reset values: prog_clk=0, prog_reset=1, ccff_head=0, isol_n=0, core_reset=1, s_ready=0, busy=0, done=0, error=0. All state returns to IDLE.
- resetb assertion mid-load forces reset values immediately (asynchronous). Partial chain contents are not cleared; a new start is required.
- All outputs are registered.
- FSM:
  - IDLE: start=1 latches bit_count and clk_div, clears done/error, sets busy=1.
    - bit_count==0: error=1, busy=0, stay IDLE, no prog_clk edges.
    - otherwise: go to PRST. start in any other state is ignored.
  - PRST: prog_reset=1, isol_n=0, core_reset=1 for RST_CYCLES clk cycles, then prog_reset=0 and go to SHIFT.
  - SHIFT: one-byte holding buffer.
    - s_ready=1 when the buffer is empty; transfer on s_valid&s_ready.
    - Each bit: ccff_head updated while prog_clk=0; prog_clk stays low D cycles, high D cycles (D=max(clk_div,1)). Period is 2D cycles.
    - A new byte is needed every 8 bits. If the buffer is empty at a bit boundary, prog_clk holds low (stall) with no extra edges until a byte arrives.
    - After the bit_count-th falling edge, unused low bits of the final byte are discarded; go to REL (or CRC if enabled).
  - REL: isol_n=1; core_reset held RST_CYCLES more cycles, then core_reset=0, done=1, busy=0, go to IDLE.
- s_ready=0 outside SHIFT. Bytes offered outside SHIFT are not consumed.
- Bit counter decrements once per prog_clk rising edge; no wrap. Maximum load is 2^CNT_W-1 bits.

Optional Feature:
- Macro: FPGA_CFG_LOADER_CRC_EN.
- Enabled: a CRC-16-CCITT (poly 0x1021, init 0xFFFF, MSB-first) is computed over exactly the bit_count shifted bits.
  - After SHIFT, state CRC accepts two further bytes (high byte first) via the same handshake, without prog_clk edges.
  - Match: go to REL.
  - Mismatch: error=1, busy=0, isol_n stays 0, core_reset stays 1, prog_reset stays 0, return to IDLE.
- Disabled: no CRC logic and no CRC state; SHIFT goes directly to REL.

Test Plan:
- bit_count=16, clk_div=1, bytes 0xA5,0x3C with s_valid=1 -> ccff_head sampled on 16 prog_clk rises = 1010_0101_0011_1100; prog_clk period 2 clk; then isol_n=1, core_reset falls 16 cycles later, done=1.
- Same load, s_valid low 10 cycles between bytes, clk_div=3 -> prog_clk held low during stall, exactly 16 rising edges, high/low phases 3 cycles each, data identical.
- bit_count=12, bytes 0xF0,0x9F -> 12 rises carry 1111_0000_1001; 2 bytes consumed; s_ready=0 afterwards; done=1.
- bit_count=0 with start -> error=1 next cycle, no prog_clk edge, isol_n=0, prog_reset stays 1.
- resetb low after 5 bits shifted -> same cycle: prog_reset=1, prog_clk=0, isol_n=0, busy=0; start ignored while resetb low; full reload after release succeeds.
- CRC_EN: 16-bit load 0x1234 with correct CRC 0x0EC9 -> done=1; with trailer 0x0EC8 -> error=1, isol_n=0, core_reset=1.
